// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM state enum and cell-index type for the sudoku loader
package sudoku_pkg;

  localparam int N        = 9;
  localparam int CELLS    = N * N;
  localparam int DIG_W    = 4;
  localparam int ONEHOT_W = N;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    CHECK,
    REPORT
  } state_t;

  typedef logic [6:0] cell_idx_t;

endpackage

// File: rtl/sudoku_digit_onehot.sv
// rtl/sudoku_digit_onehot.sv - combinational hex digit to one-hot converter
// Ports:
//   hex    in  HW  cell digit; 1..W are legal, anything else is treated as blank
//   onehot out W   bit (hex-1) set for legal digits, all zeros otherwise
module sudoku_digit_onehot #(
  parameter int W  = sudoku_pkg::ONEHOT_W,
  parameter int HW = sudoku_pkg::DIG_W
) (
  input  logic [HW-1:0] hex,
  output logic [W-1:0]  onehot
);

  // Compare against every legal value rather than shifting, so blanks and
  // out-of-range digits fall out as all-zero without a separate range test.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < W; i++) begin
      if (hex == HW'(i + 1)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sudoku_load_ctrl.sv
// rtl/sudoku_load_ctrl.sv - serial grid loader and check sequencer for the sudoku checker
// Optional feature macro: SUDOKU_LOAD_ERR_EN (sticky illegal-digit flag that skips the checker)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          begin a load (IDLE only) / return to IDLE from anywhere
//   cell_valid/cell_hex   digit offer, row-major order
//   cell_ready            digit accepted this cycle (LOAD only)
//   cell_idx              index of the next cell to be written
//   grid_bin              assembled one-hot grid, cell i at [i*N +: N]
//   chk_req/chk_ack/chk_pass  level request to the checker, completion pulse, verdict
//   busy                  state is not IDLE
//   result_valid/result_pass/result_err  one-cycle result strobe and its qualifiers
module sudoku_load_ctrl #(
  parameter int N     = sudoku_pkg::N,
  parameter int DIG_W = sudoku_pkg::DIG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               cell_valid,
  input  logic [DIG_W-1:0]   cell_hex,
  output logic               cell_ready,
  output logic [6:0]         cell_idx,
  output logic [N*N*N-1:0]   grid_bin,
  output logic               chk_req,
  input  logic               chk_ack,
  input  logic               chk_pass,
  output logic               busy,
  output logic               result_valid,
  output logic               result_pass,
  output logic               result_err
);

  import sudoku_pkg::*;

  localparam cell_idx_t LAST_IDX = cell_idx_t'(N * N - 1);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  cell_onehot;
  logic          xfer;
  logic          last_xfer;

  sudoku_digit_onehot #(
    .W  (N),
    .HW (DIG_W)
  ) u_onehot (
    .hex    (cell_hex),
    .onehot (cell_onehot)
  );

  assign xfer      = cell_valid & cell_ready;
  assign last_xfer = xfer & (cell_idx == LAST_IDX);

`ifdef SUDOKU_LOAD_ERR_EN
  logic err_flag;
  logic cell_illegal;
  logic load_err;

  assign cell_illegal = (cell_hex > DIG_W'(N));
  // Include the digit being accepted now so an illegal final cell still counts.
  assign load_err     = err_flag | (xfer & cell_illegal);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = CLEAR;
      CLEAR:  state_next = LOAD;
      LOAD: begin
        if (last_xfer) begin
`ifdef SUDOKU_LOAD_ERR_EN
          state_next = load_err ? REPORT : CHECK;
`else
          state_next = CHECK;
`endif
        end
      end
      // Only an ack seen while already in CHECK counts, so chk_req has
      // always been visible to the checker before it can complete.
      CHECK:  if (chk_ack) state_next = REPORT;
      REPORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Output decode
  always_comb begin
    cell_ready   = (state == LOAD);
    chk_req      = (state == CHECK);
    result_valid = (state == REPORT);
    busy         = (state != IDLE);
  end

  // Datapath: grid register, cell index, verdict and error latches
  always_ff @(posedge clk) begin
    if (reset) begin
      grid_bin    <= '0;
      cell_idx    <= '0;
      result_pass <= 1'b0;
`ifdef SUDOKU_LOAD_ERR_EN
      err_flag    <= 1'b0;
      result_err  <= 1'b0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          grid_bin    <= '0;
          cell_idx    <= '0;
          result_pass <= 1'b0;
`ifdef SUDOKU_LOAD_ERR_EN
          err_flag    <= 1'b0;
          result_err  <= 1'b0;
`endif
        end
        LOAD: begin
          if (xfer) begin
            grid_bin[int'(cell_idx)*N +: N] <= cell_onehot;
            // Index parks on the last cell rather than wrapping.
            if (cell_idx != LAST_IDX) begin
              cell_idx <= cell_idx + 7'd1;
            end
`ifdef SUDOKU_LOAD_ERR_EN
            err_flag <= load_err;
            if (last_xfer && load_err) begin
              result_pass <= 1'b0;
              result_err  <= 1'b1;
            end
`endif
          end
        end
        CHECK: begin
          if (chk_ack) begin
            result_pass <= chk_pass;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SUDOKU_LOAD_ERR_EN
  assign result_err = 1'b0;
`endif

endmodule

// File: tb/tb_sudoku_load_ctrl.sv
// tb/tb_sudoku_load_ctrl.sv - directed self-checking bench for sudoku_load_ctrl
module tb_sudoku_load_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic         cell_valid;
  logic [3:0]   cell_hex;
  logic         cell_ready;
  logic [6:0]   cell_idx;
  logic [728:0] grid_bin;
  logic         chk_req;
  logic         chk_ack;
  logic         chk_pass;
  logic         busy;
  logic         result_valid;
  logic         result_pass;
  logic         result_err;

  int passed = 0;
  int total  = 0;
  int hexes[81];

  always #5 clk = ~clk;

  sudoku_load_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cell_valid   (cell_valid),
    .cell_hex     (cell_hex),
    .cell_ready   (cell_ready),
    .cell_idx     (cell_idx),
    .grid_bin     (grid_bin),
    .chk_req      (chk_req),
    .chk_ack      (chk_ack),
    .chk_pass     (chk_pass),
    .busy         (busy),
    .result_valid (result_valid),
    .result_pass  (result_pass),
    .result_err   (result_err)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [728:0] obs, input logic [728:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] onehot_model(input int d);
    logic [8:0] one;
    one = 9'd1;
    if (d >= 1 && d <= 9) return one << (d - 1);
    return 9'd0;
  endfunction

  function automatic logic [728:0] exp_grid(input int ncells);
    logic [728:0] g;
    g = '0;
    for (int i = 0; i < ncells; i++) g[i*9 +: 9] = onehot_model(hexes[i]);
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Source side of the handshake: offers hexes[k], advances k on accepted transfers.
  task automatic stream(input bit stall, input int stop_at, output int cycles);
    int  k;
    bit  xfer;
    k = 0;
    cycles = 0;
    for (int s = 0; s < 1000 && k < stop_at; s++) begin
      cell_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) start = 1'($urandom_range(0, 1));
      cell_hex = 4'(hexes[k]);
      xfer = cell_valid && cell_ready;
      tick();
      cycles++;
      if (xfer) k++;
      if (stall) check_v("idx_track", 729'(cell_idx), 729'((k > 80) ? 80 : k));
    end
    cell_valid = 1'b0;
    start = 1'b0;
    check_v("load_count", 729'(k), 729'(stop_at));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cyc;

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        hexes[r*9 + c] = ((r*3 + r/3 + c) % 9) + 1;

    reset = 1'b1; start = 1'b0; abort = 1'b0; cell_valid = 1'b0;
    cell_hex = 4'd0; chk_ack = 1'b0; chk_pass = 1'b0;
    tick(); tick();

    check_b("rst_busy", busy, 1'b0);
    check_b("rst_ready", cell_ready, 1'b0);
    check_v("rst_idx", 729'(cell_idx), 729'(0));
    check_v("rst_grid", grid_bin, '0);
    check_b("rst_req", chk_req, 1'b0);
    check_b("rst_rv", result_valid, 1'b0);
    check_b("rst_rp", result_pass, 1'b0);
    check_b("rst_re", result_err, 1'b0);
    reset = 1'b0;
    tick();

    // Streaming load
    do_start();
    check_b("clear_busy", busy, 1'b1);
    check_b("clear_ready", cell_ready, 1'b0);
    stream(1'b0, 81, cyc);
    check_v("stream_latency", 729'(cyc), 729'(82));
    check_b("stream_req", chk_req, 1'b1);
    check_b("stream_ready_off", cell_ready, 1'b0);
    check_v("stream_idx_end", 729'(cell_idx), 729'(80));
    check_v("stream_grid", grid_bin, exp_grid(81));
    check_v("digit6_slice", 729'(grid_bin[5*9 +: 9]), 729'(9'b000100000));

    // Checker ack after 5 cycles, pass
    wait_cycles(5);
    check_b("req_held", chk_req, 1'b1);
    check_b("no_early_rv", result_valid, 1'b0);
    chk_ack = 1'b1; chk_pass = 1'b1;
    tick();
    chk_ack = 1'b0; chk_pass = 1'b0;
    check_b("rep_rv", result_valid, 1'b1);
    check_b("rep_pass", result_pass, 1'b1);
    check_b("rep_err", result_err, 1'b0);
    check_b("rep_req_off", chk_req, 1'b0);
    tick();
    check_b("rep_one_cycle", result_valid, 1'b0);
    check_b("idle_busy", busy, 1'b0);
    check_v("idle_grid_held", grid_bin, exp_grid(81));

    // Stalled load, start toggling while busy, ack held during entry to CHECK
    do_start();
    chk_ack = 1'b1; chk_pass = 1'b1;
    stream(1'b1, 81, cyc);
    chk_ack = 1'b0; chk_pass = 1'b0;
    check_b("stall_req", chk_req, 1'b1);
    check_b("stall_entry_ack_ignored", result_valid, 1'b0);
    check_v("stall_grid", grid_bin, exp_grid(81));
    wait_cycles(5);
    chk_ack = 1'b1; chk_pass = 1'b0;
    tick();
    chk_ack = 1'b0;
    check_b("fail_rv", result_valid, 1'b1);
    check_b("fail_pass", result_pass, 1'b0);
    tick();
    check_b("fail_idle", busy, 1'b0);

    // Abort at cell 40
    do_start();
    stream(1'b0, 40, cyc);
    check_v("abort_idx_before", 729'(cell_idx), 729'(40));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_b("abort_busy", busy, 1'b0);
    check_b("abort_ready", cell_ready, 1'b0);
    check_b("abort_req", chk_req, 1'b0);
    check_b("abort_rv", result_valid, 1'b0);
    check_v("abort_grid_partial", grid_bin, exp_grid(40));
    wait_cycles(3);
    check_b("abort_no_rv_later", result_valid, 1'b0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check_b("abort_beats_start", busy, 1'b0);
    do_start();
    tick();
    check_v("restart_grid_zero", grid_bin, '0);
    check_v("restart_idx_zero", 729'(cell_idx), 729'(0));
    check_b("restart_ready", cell_ready, 1'b1);

    // Illegal digit at cell 12 (continues the load already in LOAD)
    hexes[12] = 11;
    stream(1'b0, 81, cyc);
    check_v("illegal_slice", 729'(grid_bin[12*9 +: 9]), 729'(9'd0));
    check_v("illegal_grid", grid_bin, exp_grid(81));
`ifdef SUDOKU_LOAD_ERR_EN
    check_b("err_req_off", chk_req, 1'b0);
    check_b("err_rv", result_valid, 1'b1);
    check_b("err_pass", result_pass, 1'b0);
    check_b("err_flag", result_err, 1'b1);
    tick();
    check_b("err_idle", busy, 1'b0);
`else
    check_b("noerr_req", chk_req, 1'b1);
    chk_ack = 1'b1; chk_pass = 1'b1;
    tick();
    chk_ack = 1'b0; chk_pass = 1'b0;
    check_b("noerr_rv", result_valid, 1'b1);
    check_b("noerr_pass", result_pass, 1'b1);
    check_b("noerr_err", result_err, 1'b0);
    tick();
`endif
    hexes[12] = 7;

    // Reset during CHECK
    do_start();
    stream(1'b0, 81, cyc);
    check_b("pre_reset_req", chk_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_b("reset_req", chk_req, 1'b0);
    check_b("reset_busy", busy, 1'b0);
    check_v("reset_grid", grid_bin, '0);
    check_v("reset_idx", 729'(cell_idx), 729'(0));
    check_b("reset_rv", result_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
